hgcal_input_packer: RTL

Streaming front end of the HGCAL autoencoder LUT network. Accepts raw per-cell charge samples one per cycle, quantizes each to a 2-bit code with fixed thresholds, and packs a full frame of codes into one wide input vector. That vector drives the first neuron layer, whose 2-bit activations feed layer 1. Double-buffered, so frame N+1 is assembled while frame N waits on the network.

---
 rtl/hgcal_pkg.sv | 19 +
 rtl/hgcal_quantizer.sv | 28 ++
 rtl/hgcal_input_packer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/hgcal_pkg.sv
// Shared constants for the HGCAL input packer: default geometry,
// quantization thresholds and packer state encoding.
package hgcal_pkg;

    localparam int DEF_N_IN = 48;
    localparam int DEF_IN_W = 8;
    localparam int DEF_Q_W  = 2;

    localparam logic [DEF_IN_W-1:0] DEF_THR0 = 8'd8;
    localparam logic [DEF_IN_W-1:0] DEF_THR1 = 8'd32;
    localparam logic [DEF_IN_W-1:0] DEF_THR2 = 8'd96;

    typedef logic [1:0] state_t;

    localparam state_t ST_FILL   = 2'd0;
    localparam state_t ST_HOLD   = 2'd1;
    localparam state_t ST_RESYNC = 2'd2;

endpackage

// File: rtl/hgcal_quantizer.sv
// Combinational 3-threshold quantizer: the code is the number of
// thresholds the sample has reached (equality counts as reached).
module hgcal_quantizer
    import hgcal_pkg::*;
#(
    parameter int              IN_W = DEF_IN_W,
    parameter int              Q_W  = DEF_Q_W,
    parameter logic [IN_W-1:0] THR0 = DEF_THR0,
    parameter logic [IN_W-1:0] THR1 = DEF_THR1,
    parameter logic [IN_W-1:0] THR2 = DEF_THR2
) (
    input  logic [IN_W-1:0] data,
    output logic [Q_W-1:0]  code
);

    // Thresholds are ascending, so the highest one reached decides the code.
    always_comb begin
        code = '0;
        if (data >= THR2) begin
            code = Q_W'(3);
        end else if (data >= THR1) begin
            code = Q_W'(2);
        end else if (data >= THR0) begin
            code = Q_W'(1);
        end
    end

endmodule

// File: rtl/hgcal_input_packer.sv
// Streaming packer: quantizes one sample per cycle into an assembly
// register and hands complete frames to a double-buffered output register.
module hgcal_input_packer
    import hgcal_pkg::*;
#(
    parameter int              N_IN = DEF_N_IN,
    parameter int              IN_W = DEF_IN_W,
    parameter int              Q_W  = DEF_Q_W,
    parameter logic [IN_W-1:0] THR0 = DEF_THR0,
    parameter logic [IN_W-1:0] THR1 = DEF_THR1,
    parameter logic [IN_W-1:0] THR2 = DEF_THR2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [IN_W-1:0]     s_data,
    input  logic                s_last,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [N_IN*Q_W-1:0] m_data,
    output logic                err_frame
);

    localparam int                IDX_W    = $clog2(N_IN);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_IN - 1);

    state_t                       state;
    logic [IDX_W-1:0]             idx;
    logic [N_IN-1:0][Q_W-1:0]     asm_q;
    logic [N_IN-1:0][Q_W-1:0]     asm_next;
    logic [N_IN-1:0][Q_W-1:0]     out_q;
    logic [Q_W-1:0]               code;
    logic                         xfer;
    logic                         at_last;
    logic                         out_free;

    hgcal_quantizer #(
        .IN_W (IN_W),
        .Q_W  (Q_W),
        .THR0 (THR0),
        .THR1 (THR1),
        .THR2 (THR2)
    ) u_quant (
        .data (s_data),
        .code (code)
    );

    assign s_ready  = (state != ST_HOLD);
    assign xfer     = s_valid && s_ready;
    assign at_last  = (idx == IDX_LAST);
    assign out_free = !m_valid || m_ready;
    assign m_data   = out_q;

    // Assembly contents including the sample being accepted this cycle,
    // so a completing frame can go straight to the output register.
    always_comb begin
        asm_next      = asm_q;
        asm_next[idx] = code;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_FILL;
            idx       <= '0;
            asm_q     <= '0;
            out_q     <= '0;
            m_valid   <= 1'b0;
            err_frame <= 1'b0;
        end else begin
            err_frame <= 1'b0;
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end

            case (state)
                ST_FILL: begin
                    if (xfer) begin
                        asm_q <= asm_next;
                        if (at_last && s_last) begin
                            idx <= '0;
                            if (out_free) begin
                                out_q   <= asm_next;
                                m_valid <= 1'b1;
                            end else begin
                                state <= ST_HOLD;
                            end
                        end else if (s_last) begin
                            err_frame <= 1'b1;
                            idx       <= '0;
                        end else if (at_last) begin
                            err_frame <= 1'b1;
                            idx       <= '0;
                            state     <= ST_RESYNC;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end

                // A finished frame waits here until the consumer frees the output.
                ST_HOLD: begin
                    if (out_free) begin
                        out_q   <= asm_q;
                        m_valid <= 1'b1;
                        state   <= ST_FILL;
                    end
                end

                ST_RESYNC: begin
                    if (xfer && s_last) begin
                        state <= ST_FILL;
                    end
                end

                default: begin
                    state <= ST_FILL;
                    idx   <= '0;
                end
            endcase
        end
    end

endmodule
